// File: rtl/wb_regfile_if.sv
// Writeback-stage bundle: MEM/WB outputs in, decode read ports
// and writeback result / retire count out.
interface wb_regfile_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 64
);
  logic            RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ALUResultW;
  logic [XLEN-1:0] ReadDataW;
  logic [XLEN-1:0] PCPlus4W;
  logic [XLEN-1:0] ExtImmW;
  logic            ValidW;
  logic [4:0]      A1D;
  logic [4:0]      A2D;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [XLEN-1:0] ResultW;
  logic [CNTW-1:0] InstRet;

  modport master (
    output RegWriteW, ResultSrcW, RdW,
    output ALUResultW, ReadDataW,
    output PCPlus4W, ExtImmW, ValidW,
    output A1D, A2D,
    input  RD1D, RD2D, ResultW, InstRet
  );

  modport slave (
    input  RegWriteW, ResultSrcW, RdW,
    input  ALUResultW, ReadDataW,
    input  PCPlus4W, ExtImmW, ValidW,
    input  A1D, A2D,
    output RD1D, RD2D, ResultW, InstRet
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32I writeback stage: result select, 32x32 register file
// with write-through read bypass, and retired-instruction counter.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNTW  = 64
) (
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave w
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [CNTW-1:0] instret_q;
  logic [CNTW-1:0] instret_d;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            we;

  always_comb begin
    result = w.ALUResultW;
    unique case (w.ResultSrcW)
      2'b00: result = w.ALUResultW;
      2'b01: result = w.ReadDataW;
      2'b10: result = w.PCPlus4W;
      2'b11: result = w.ExtImmW;
    endcase
  end

  assign we = w.RegWriteW & w.ValidW
            & (w.RdW != 5'd0);

  // Bypass lets decode see a same-cycle writeback.
  always_comb begin
    rd1 = '0;
    if (w.A1D != 5'd0) begin
      if (we && (w.A1D == w.RdW)) rd1 = result;
      else                        rd1 = regs_q[w.A1D];
    end
  end

  always_comb begin
    rd2 = '0;
    if (w.A2D != 5'd0) begin
      if (we && (w.A2D == w.RdW)) rd2 = result;
      else                        rd2 = regs_q[w.A2D];
    end
  end

  assign instret_d = w.ValidW ? instret_q + 1'b1
                              : instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[w.RdW] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign w.ResultW = result;
  assign w.RD1D    = rd1;
  assign w.RD2D    = rd2;
  assign w.InstRet = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed plan items
// plus randomized traffic against an array/counter model.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .w   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_reg [32];
  logic [63:0] m_cnt;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_res();
    logic [31:0] src [4];
    src[0] = bus.ALUResultW;
    src[1] = bus.ReadDataW;
    src[2] = bus.PCPlus4W;
    src[3] = bus.ExtImmW;
    return src[bus.ResultSrcW];
  endfunction

  function automatic bit m_we();
    return bus.RegWriteW && bus.ValidW && bus.RdW != 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == bus.RdW) return m_res();
    return m_reg[a];
  endfunction

  task automatic set_w(input bit rw, input logic [1:0] src,
                       input logic [4:0] rd,
                       input logic [31:0] alu,
                       input logic [31:0] ld,
                       input logic [31:0] pc,
                       input logic [31:0] imm,
                       input bit v);
    bus.RegWriteW  = rw;
    bus.ResultSrcW = src;
    bus.RdW        = rd;
    bus.ALUResultW = alu;
    bus.ReadDataW  = ld;
    bus.PCPlus4W   = pc;
    bus.ExtImmW    = imm;
    bus.ValidW     = v;
  endtask

  // Advance one edge; the model commits with the same rules.
  task automatic tick();
    bit          we;
    logic [31:0] r;
    logic [4:0]  d;
    we = m_we();
    r  = m_res();
    d  = bus.RdW;
    @(posedge clk);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_cnt = 64'h0;
    end else begin
      if (we) m_reg[d] = r;
      if (bus.ValidW) m_cnt = m_cnt + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    set_w(0, 2'b00, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [63:0] c0;

  initial begin
    foreach (m_reg[i]) m_reg[i] = 32'h0;
    m_cnt = 64'h0;
    idle();
    bus.A1D = 5'd0;
    bus.A2D = 5'd0;
    @(negedge clk);

    // Reset then read sweep
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus.A1D = 5'(i);
      bus.A2D = 5'(31 - i);
      #1;
      chk("rst_rd1", bus.RD1D, 0);
      chk("rst_rd2", bus.RD2D, 0);
    end
    chk("rst_cnt", bus.InstRet, 0);

    // Source select
    for (int s = 0; s < 4; s++) begin
      set_w(1, 2'(s), 5'(5 + s), 32'h11, 32'h22,
            32'h33, 32'h44, 1);
      #1;
      chk("sel_res", bus.ResultW, 64'(32'h11 * (s + 1)));
      tick();
    end
    idle();
    for (int s = 0; s < 4; s++) begin
      bus.A1D = 5'(5 + s);
      bus.A2D = 5'(8 - s);
      #1;
      chk("sel_rd1", bus.RD1D, 64'(32'h11 * (s + 1)));
      chk("sel_rd2", bus.RD2D, 64'(32'h11 * (4 - s)));
    end
    chk("sel_cnt", bus.InstRet, 4);

    // Same-cycle bypass on both ports
    set_w(1, 2'b00, 5'd9, 32'hDEADBEEF, 0, 0, 0, 1);
    bus.A1D = 5'd9;
    bus.A2D = 5'd9;
    #1;
    chk("byp_rd1", bus.RD1D, 32'hDEADBEEF);
    chk("byp_rd2", bus.RD2D, 32'hDEADBEEF);
    tick();
    bus.RegWriteW = 1'b0;
    #1;
    chk("stor_rd1", bus.RD1D, 32'hDEADBEEF);
    chk("stor_rd2", bus.RD2D, 32'hDEADBEEF);

    // x0 stays zero
    set_w(1, 2'b00, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 1);
    bus.A1D = 5'd0;
    #1;
    chk("x0_byp", bus.RD1D, 0);
    chk("x0_res", bus.ResultW, 32'hFFFFFFFF);
    tick();
    idle();
    #1;
    chk("x0_stor", bus.RD1D, 0);

    // Bubble with RegWriteW set
    c0 = bus.InstRet;
    set_w(1, 2'b00, 5'd3, 32'hAAAA5555, 0, 0, 0, 0);
    bus.A1D = 5'd3;
    tick();
    idle();
    #1;
    chk("bub_x3", bus.RD1D, 0);
    chk("bub_cnt", bus.InstRet, c0);

    // Count 10 valid + 3 bubbles from reset
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_w(i[0], 2'b00, 5'(10 + i), 32'(i), 0, 0, 0, i < 10);
      tick();
    end
    idle();
    #1;
    chk("cnt10", bus.InstRet, 10);
    chk("cnt10m", bus.InstRet, m_cnt);

    // Wrap from all-ones
    force dut.instret_q = '1;
    #1;
    chk("wrap_pre", bus.InstRet, 64'hFFFF_FFFF_FFFF_FFFF);
    release dut.instret_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    set_w(0, 2'b00, 5'd0, 0, 0, 0, 0, 1);
    tick();
    idle();
    #1;
    chk("wrap", bus.InstRet, 0);

    // Reset mid-stream discards the W instruction
    do_reset();
    set_w(1, 2'b00, 5'd4, 32'h1234, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_w(0, 2'b01, 5'd4, 0, 32'hBAD, 0, 0, 1);
      tick();
    end
    idle();
    bus.A1D = 5'd4;
    #1;
    chk("mid_x4", bus.RD1D, 32'h1234);
    chk("mid_cnt", bus.InstRet, 7);
    set_w(1, 2'b00, 5'd4, 32'h5678, 0, 0, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("mrst_x4", bus.RD1D, 0);
    chk("mrst_cnt", bus.InstRet, 0);
    set_w(1, 2'b11, 5'd4, 0, 0, 0, 32'h9ABC, 1);
    tick();
    idle();
    #1;
    chk("resume_x4", bus.RD1D, 32'h9ABC);
    chk("resume_cnt", bus.InstRet, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      set_w($urandom_range(0, 3) != 0, 2'($urandom),
            5'($urandom), $urandom, $urandom,
            $urandom, $urandom, $urandom_range(0, 4) != 0);
      bus.A1D = ($urandom_range(0, 3) == 0) ? bus.RdW
                                            : 5'($urandom);
      bus.A2D = ($urandom_range(0, 3) == 0) ? bus.RdW
                                            : 5'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      #1;
      chk("r_res", bus.ResultW, m_res());
      chk("r_rd1", bus.RD1D, m_rd(bus.A1D));
      chk("r_rd2", bus.RD2D, m_rd(bus.A2D));
      chk("r_cnt", bus.InstRet, m_cnt);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
